// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor: coin codes, emitter
// states and the unit value of each coin.
package coin_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        CIRCLE   = 2'b01,
        TRIANGLE = 2'b10,
        PENTAGON = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } emit_state_t;

    localparam int unsigned UNIT_CIRCLE   = 1;
    localparam int unsigned UNIT_TRIANGLE = 3;
    localparam int unsigned UNIT_PENTAGON = 5;

    function automatic logic [2:0] coin_units(coin_t code);
        case (code)
            CIRCLE:   return 3'(UNIT_CIRCLE);
            TRIANGLE: return 3'(UNIT_TRIANGLE);
            PENTAGON: return 3'(UNIT_PENTAGON);
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor-in / coin-code-out bundle of the coin acceptor.
// tally is present only when COIN_ACCEPTOR_TALLY_EN is defined.
interface coin_acceptor_if;
    import coin_pkg::*;

    logic  sense_circle;
    logic  sense_triangle;
    logic  sense_pentagon;
    coin_t coin;
    logic  busy;
    logic  full;
    logic  reject;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [7:0] tally;

    modport master (
        input  sense_circle, sense_triangle, sense_pentagon,
        output coin, busy, full, reject, tally
    );

    modport slave (
        output sense_circle, sense_triangle, sense_pentagon,
        input  coin, busy, full, reject, tally
    );
`else
    modport master (
        input  sense_circle, sense_triangle, sense_pentagon,
        output coin, busy, full, reject
    );

    modport slave (
        output sense_circle, sense_triangle, sense_pentagon,
        input  coin, busy, full, reject
    );
`endif

endinterface

// File: rtl/coin_debounce.sv
// One sensor line: input sample register, stability counter and debounced
// level. rise is high in the cycle whose edge flips the level 0->1.
module coin_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sense,
    output logic rise
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sample;
    logic          level;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          flip;

    assign differ = (sample != level);
    // Counter would reach DEBOUNCE on this edge: flip instead of counting.
    assign flip   = differ && (cnt == CW'(DEBOUNCE - 1));
    assign rise   = flip && !level;

    always_ff @(posedge clock) begin
        if (reset) begin
            sample <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sample <= sense;
            if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: debounces three coin sensors, queues accepted coins and
// emits each as a one-cycle code followed by an idle gap.
// Optional unit counter on the tally port: define COIN_ACCEPTOR_TALLY_EN.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned GAP      = 1,
    parameter int unsigned DEPTH    = 4
) (
    input  logic            clock,
    input  logic            reset,
    coin_acceptor_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic rise_circle;
    logic rise_triangle;
    logic rise_pentagon;

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_circle (
        .clock (clock),
        .reset (reset),
        .sense (bus.sense_circle),
        .rise  (rise_circle)
    );

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_triangle (
        .clock (clock),
        .reset (reset),
        .sense (bus.sense_triangle),
        .rise  (rise_triangle)
    );

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_pentagon (
        .clock (clock),
        .reset (reset),
        .sense (bus.sense_pentagon),
        .rise  (rise_pentagon)
    );

    logic [2:0] events;
    logic       one_event;
    logic       multi_event;
    coin_t      event_code;

    assign events      = {rise_pentagon, rise_triangle, rise_circle};
    assign one_event   = $onehot(events);
    assign multi_event = (events != 3'b000) && !one_event;

    always_comb begin
        event_code = NONE;
        case (events)
            3'b001:  event_code = CIRCLE;
            3'b010:  event_code = TRIANGLE;
            3'b100:  event_code = PENTAGON;
            default: event_code = NONE;
        endcase
    end

    // Coin queue; the extra pointer MSB separates full from empty.
    coin_t         q_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_d;
    logic          q_empty;
    logic          q_full;
    logic          push;
    logic          pop;
    logic          drop;

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A full queue still accepts a coin when the emitter pops in the same cycle.
    assign push     = one_event && (!q_full || pop);
    assign drop     = one_event && q_full && !pop;
    assign wr_ptr_d = wr_ptr + PW'(push);
    assign rd_ptr_d = rd_ptr + PW'(pop);

    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_ptr[AW-1:0]] <= event_code;
        end
    end

    emit_state_t   state;
    emit_state_t   state_d;
    coin_t         coin_d;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_d;

    // Emitter next-state: pop in IDLE, one code cycle in EMIT, then GAP idles.
    always_comb begin
        state_d   = state;
        coin_d    = NONE;
        gap_cnt_d = gap_cnt;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    coin_d  = q_mem[rd_ptr[AW-1:0]];
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                gap_cnt_d = GW'(GAP - 1);
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bus.coin   <= NONE;
            bus.busy   <= 1'b0;
            bus.full   <= 1'b0;
            bus.reject <= 1'b0;
        end else begin
            state      <= state_d;
            gap_cnt    <= gap_cnt_d;
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            bus.coin   <= coin_d;
            bus.busy   <= (wr_ptr_d != rd_ptr_d) || (state_d != ST_IDLE);
            bus.full   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                          (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            bus.reject <= multi_event || drop;
        end
    end

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [8:0] tally_sum;

    assign tally_sum = 9'(bus.tally) + 9'(coin_units(coin_d));

    // Saturating count of units handed to the vending FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.tally <= 8'd0;
        end else if (pop) begin
            bus.tally <= tally_sum[8] ? 8'hFF : tally_sum[7:0];
        end
    end
`endif

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin validator for the vending controller. It debounces three raw coin-sensor lines and queues accepted coins. Each coin is sent to the vending FSM's `coin[1:0]` input as a one-cycle code, with a guaranteed idle gap between codes. It is the producing end of the coin-code interface: 01 = circle (1 unit), 10 = triangle (3 units), 11 = pentagon (5 units), 00 = no coin.

## Interface
- `DEBOUNCE`, default 4: consecutive cycles a sensor must differ from its debounced level before that level flips (≥1).
- `GAP`, default 1: cycles of `coin`=00 forced after every emitted code (≥1).
- `DEPTH`, default 4: coin queue entries (power of two, ≥2).
- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `sense_circle` input 1: raw circle sensor, high while coin present.
- `sense_triangle` input 1: raw triangle sensor.
- `sense_pentagon` input 1: raw pentagon sensor.
- `coin` output 2: registered coin code to vending FSM.
- `busy` output 1: queue non-empty or emitter not IDLE.
- `full` output 1: queue holds DEPTH entries.
- `reject` output 1: one-cycle pulse, detected coin discarded.
- `tally` output 8: total units emitted (only with macro, see Configuration).

## Operation
- Each sensor is sampled into a register, then debounced (`coin_debounce`).
  - A counter increments while the sampled value ≠ the debounced level. It clears when they are equal.
  - When the counter would reach DEBOUNCE, the level flips and the counter clears.
- Detect event: a debounced 0→1 flip. Falling flips produce nothing.
- Events in the same cycle:
  - Exactly one event: enqueue its code.
  - Two or more events: `reject` pulses next cycle and nothing is enqueued.
- Event while `full`:
  - No pop in that cycle: the coin is dropped and `reject` pulses.
  - Pop in the same cycle: the coin is accepted (simultaneous push/pop allowed).
- Emitter FSM states and transitions:
  - IDLE: if the queue is non-empty, pop the head into the `coin` register and go to EMIT. Otherwise `coin` register ← 00.
  - EMIT: `coin` shows the code for exactly this cycle. Load `coin` ← 00 and go to GAP with the gap counter = GAP−1.
  - GAP: `coin`=00. Decrement the counter; at 0 go to IDLE.
- Codes are emitted in arrival order, never merged or skipped.
- Queue pointers are log2(DEPTH)+1 bits. Full/empty are decided by comparing the MSBs; pointers wrap naturally.

## Timing
- Reset values:
  - `coin`=00, `busy`=0, `full`=0, `reject`=0, `tally`=0.
  - Queue empty, FSM in IDLE, debounced levels 0, counters 0.
- Latency (idle, empty queue): take the edge that first samples a sensor high as edge 1.
  - Enqueue occurs at edge DEBOUNCE+1.
  - Pop occurs at edge DEBOUNCE+2.
  - `coin` is non-zero for the one cycle following edge DEBOUNCE+2.
- Back-to-back queued coins emit every GAP+2 cycles: IDLE(pop), EMIT, GAP×GAP.
- Reset mid-operation:
  - Queue is flushed and any in-flight code is lost.
  - `coin`=00 the cycle after the reset edge.
- A sensor still high when reset deasserts counts as a new coin after DEBOUNCE cycles.
- Sensor glitches shorter than DEBOUNCE cycles produce no event.

## Configuration
- `COIN_ACCEPTOR_TALLY_EN`
  - Defined: the `tally` port exists. It adds 1/3/5 at each pop, saturates at 255, and clears only on reset.
  - Undefined: the port and its adder are absent. All other behaviour is identical.

## Structure
- Package `coin_pkg` holds:
  - Enum `coin_t` {NONE=2'b00, CIRCLE=2'b01, TRIANGLE=2'b10, PENTAGON=2'b11}.
  - Emitter state enum {IDLE, EMIT, GAP}.
  - Unit-value constants 1/3/5.
- Sub-module `coin_debounce`: sample register, counter and debounced level, with output `rise`. Instantiated three times.

## Test plan
- **Single coin:** pentagon held high 10 cycles, DEBOUNCE=4 → `coin`=11 for exactly one cycle after edge 6, then 00; tally=5.
- **Glitch:** circle high 3 cycles → no `coin` change, no `reject`.
- **Simultaneous:** triangle and circle rise together and both stay high → `reject` one pulse, `coin` stays 00.
- **Burst:**
  - Stimulus: five single coins (1,3,5,1,3) debounced before any pop completes, DEPTH=4, GAP=1.
  - Expected: one `reject` for the fifth only if no pop overlapped.
  - Expected: codes emitted in order, spaced 3 cycles apart.
  - Expected: `full` asserts at 4 entries.
- **Reset mid-burst:** reset during EMIT with 2 entries queued → `coin`=00 next cycle, `busy`=0, no further codes.
- **Tally saturation:** 52 pentagons (macro defined) → `tally`=255, holds.
